regfile_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 4×16 register file between three writeback requesters (ALU, load unit, debug port). Each requester uses a valid/ready handshake. One accepted write per cycle is registered and driven onto the register file's active-low write port on the following cycle. A per-register pending mask lets read-side logic detect that a register has an accepted write that has not yet committed. The block also keeps a saturating count of contention cycles for performance monitoring.

---
 rtl/regfile_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file's single active-low write port between
// three writeback requesters, with a pending-write mask and a saturating contention counter.
module regfile_wr_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [2:0]               req_valid,
  input  logic [ADDR_WIDTH-1:0]    req_addr0,
  input  logic [ADDR_WIDTH-1:0]    req_addr1,
  input  logic [ADDR_WIDTH-1:0]    req_addr2,
  input  logic [DATA_WIDTH-1:0]    req_data0,
  input  logic [DATA_WIDTH-1:0]    req_data1,
  input  logic [DATA_WIDTH-1:0]    req_data2,
  output logic [2:0]               req_ready,
  output logic                     rf_wr,
  output logic [ADDR_WIDTH-1:0]    rf_address_wr,
  output logic [DATA_WIDTH-1:0]    rf_data_in,
  output logic [2**ADDR_WIDTH-1:0] pending_mask,
  output logic [1:0]               last_grant,
  output logic [CNT_WIDTH-1:0]     conflict_cnt
);

  logic [1:0]            ptr_q;
  logic                  out_valid_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [1:0]            last_grant_q;
  logic [CNT_WIDTH-1:0]  conflict_cnt_q;

  logic                  accept;
  logic                  contention;
  logic [1:0]            gnt_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Priority scan starting at ptr; ready is forced low while reset is asserted.
  always_comb begin
    req_ready = 3'b000;
    if (!reset && !hold) begin
      case (ptr_q)
        2'd1: begin
          if (req_valid[1])      req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
          else if (req_valid[0]) req_ready = 3'b001;
        end
        2'd2: begin
          if (req_valid[2])      req_ready = 3'b100;
          else if (req_valid[0]) req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
        end
        default: begin
          if (req_valid[0])      req_ready = 3'b001;
          else if (req_valid[1]) req_ready = 3'b010;
          else if (req_valid[2]) req_ready = 3'b100;
        end
      endcase
    end
  end

  assign accept = |req_ready;

  always_comb begin
    gnt_idx  = 2'd0;
    sel_addr = req_addr0;
    sel_data = req_data0;
    case (req_ready)
      3'b010: begin
        gnt_idx  = 2'd1;
        sel_addr = req_addr1;
        sel_data = req_data1;
      end
      3'b100: begin
        gnt_idx  = 2'd2;
        sel_addr = req_addr2;
        sel_data = req_data2;
      end
      default: ;
    endcase
  end

  assign contention = !hold && ((req_valid[0] && req_valid[1]) ||
                                (req_valid[0] && req_valid[2]) ||
                                (req_valid[1] && req_valid[2]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q          <= 2'd0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
      last_grant_q   <= 2'd0;
      conflict_cnt_q <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_addr_q   <= sel_addr;
        out_data_q   <= sel_data;
        last_grant_q <= gnt_idx;
        ptr_q        <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end
      if (contention && (conflict_cnt_q != {CNT_WIDTH{1'b1}})) begin
        conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    if (out_valid_q) pending_mask[out_addr_q] = 1'b1;
  end

  assign rf_wr         = ~out_valid_q;
  assign rf_address_wr = out_addr_q;
  assign rf_data_in    = out_data_q;
  assign last_grant    = last_grant_q;
  assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small register-file model on the write port.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [2:0]  req_valid;
  logic [1:0]  req_addr0, req_addr1, req_addr2;
  logic [15:0] req_data0, req_data1, req_data2;
  logic [2:0]  req_ready;
  logic        rf_wr;
  logic [1:0]  rf_address_wr;
  logic [15:0] rf_data_in;
  logic [3:0]  pending_mask;
  logic [1:0]  last_grant;
  logic [3:0]  conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [4] = '{default: 16'h0000};

  always #5 clk = ~clk;

  // Register file: commits on rising edge while the active-low enable is low.
  always @(posedge clk) if (!rf_wr) mem[rf_address_wr] <= rf_data_in;

  regfile_wr_arbiter #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(2),
    .CNT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .req_addr2    (req_addr2),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .req_data2    (req_data2),
    .req_ready    (req_ready),
    .rf_wr        (rf_wr),
    .rf_address_wr(rf_address_wr),
    .rf_data_in   (rf_data_in),
    .pending_mask (pending_mask),
    .last_grant   (last_grant),
    .conflict_cnt (conflict_cnt)
  );

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; req_valid = 3'b111;
    req_addr0 = 2'd0; req_addr1 = 2'd1; req_addr2 = 2'd2;
    req_data0 = 16'h1111; req_data1 = 16'h2222; req_data2 = 16'h3333;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++;
      $display("FAIL reset_ready got=%b want=000", req_ready); end
    n_cmp++; if (rf_wr !== 1'b1) begin n_bad++;
      $display("FAIL reset_rf_wr got=%b want=1", rf_wr); end
    n_cmp++; if (pending_mask !== 4'b0000 || last_grant !== 2'd0 || conflict_cnt !== 4'h0) begin
      n_bad++; $display("FAIL reset_state pm=%b lg=%0d cc=%0d want 0/0/0",
                        pending_mask, last_grant, conflict_cnt); end
    n_cmp++; if (rf_address_wr !== 2'd0 || rf_data_in !== 16'h0) begin n_bad++;
      $display("FAIL reset_rf_bus addr=%0d data=%h want 0/0000", rf_address_wr, rf_data_in); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] exp_r [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++;
      $display("FAIL rr_first_ready got=%b want=001", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (last_grant !== exp_g[i] || rf_wr !== 1'b0 || req_ready !== exp_r[i]) begin
        n_bad++; $display("FAIL rr_grant%0d lg=%0d wr=%b rdy=%b want lg=%0d wr=0 rdy=%b",
                          i, last_grant, rf_wr, req_ready, exp_g[i], exp_r[i]); end
      n_cmp++; if (rf_address_wr !== exp_g[i] || conflict_cnt !== 4'(i + 1)) begin n_bad++;
        $display("FAIL rr_out%0d addr=%0d cc=%0d want addr=%0d cc=%0d",
                 i, rf_address_wr, conflict_cnt, exp_g[i], i + 1); end
    end
    req_valid = 3'b000;
    @(posedge clk); #1;
    n_cmp++; if (mem[0] !== 16'h1111 || mem[1] !== 16'h2222 || mem[2] !== 16'h3333) begin
      n_bad++; $display("FAIL rr_mem got=%h %h %h want=1111 2222 3333", mem[0], mem[1], mem[2]); end
  endtask

  task automatic test_single();
    // ptr = 1 after the round-robin run
    req_valid = 3'b010; req_addr1 = 2'd3; req_data1 = 16'hBEEF;
    @(posedge clk); #1;
    req_valid = 3'b000;
    n_cmp++; if (rf_wr !== 1'b0 || pending_mask !== 4'b1000 || last_grant !== 2'd1) begin
      n_bad++; $display("FAIL single_E1 wr=%b pm=%b lg=%0d want 0/1000/1",
                        rf_wr, pending_mask, last_grant); end
    n_cmp++; if (mem[3] !== 16'h0000 || conflict_cnt !== 4'd4) begin n_bad++;
      $display("FAIL single_old mem3=%h cc=%0d want 0000/4", mem[3], conflict_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (rf_wr !== 1'b1 || pending_mask !== 4'b0000 || rf_data_in !== 16'hBEEF) begin
      n_bad++; $display("FAIL single_E2 wr=%b pm=%b data=%h want 1/0000/BEEF",
                        rf_wr, pending_mask, rf_data_in); end
    n_cmp++; if (mem[3] !== 16'hBEEF) begin n_bad++;
      $display("FAIL single_mem3 got=%h want=BEEF", mem[3]); end
  endtask

  task automatic test_hold();
    // ptr = 2 here
    hold = 1'b1; req_valid = 3'b101;
    req_addr0 = 2'd0; req_data0 = 16'h0A0A; req_addr2 = 2'd0; req_data2 = 16'h0C0C;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++;
      $display("FAIL hold_ready got=%b want=000", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (rf_wr !== 1'b1 || conflict_cnt !== 4'd4) begin n_bad++;
      $display("FAIL hold_nowrite wr=%b cc=%0d want 1/4", rf_wr, conflict_cnt); end
    hold = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_bad++;
      $display("FAIL hold_release_ready got=%b want=100", req_ready); end
    @(posedge clk); #1;
    req_valid = 3'b000;
    n_cmp++; if (last_grant !== 2'd2 || conflict_cnt !== 4'd5 || rf_data_in !== 16'h0C0C) begin
      n_bad++; $display("FAIL hold_grant lg=%0d cc=%0d data=%h want 2/5/0C0C",
                        last_grant, conflict_cnt, rf_data_in); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    // ptr = 0 here: requester 0 wins, then requester 2
    req_addr0 = 2'd1; req_data0 = 16'hAAAA; req_addr2 = 2'd1; req_data2 = 16'hBBBB;
    req_valid = 3'b101;
    @(posedge clk); #1;
    req_valid = 3'b100;
    n_cmp++; if (last_grant !== 2'd0 || rf_data_in !== 16'hAAAA || conflict_cnt !== 4'd6) begin
      n_bad++; $display("FAIL b2b_first lg=%0d data=%h cc=%0d want 0/AAAA/6",
                        last_grant, rf_data_in, conflict_cnt); end
    @(posedge clk); #1;
    req_valid = 3'b000;
    n_cmp++; if (last_grant !== 2'd2 || mem[1] !== 16'hAAAA || conflict_cnt !== 4'd6) begin
      n_bad++; $display("FAIL b2b_second lg=%0d mem1=%h cc=%0d want 2/AAAA/6",
                        last_grant, mem[1], conflict_cnt); end
    @(posedge clk); #1;
    n_cmp++; if (mem[1] !== 16'hBBBB) begin n_bad++;
      $display("FAIL b2b_final mem1=%h want=BBBB", mem[1]); end
  endtask

  task automatic test_reset_midcycle();
    // ptr = 0; only requester 1 valid, targets register 2 (holds 3333)
    req_valid = 3'b010; req_addr1 = 2'd2; req_data1 = 16'h5555;
    @(posedge clk); #1;
    req_valid = 3'b000;
    n_cmp++; if (rf_wr !== 1'b0 || pending_mask !== 4'b0100) begin n_bad++;
      $display("FAIL mid_pre wr=%b pm=%b want 0/0100", rf_wr, pending_mask); end
    #2; reset = 1'b1; #1;
    n_cmp++; if (rf_wr !== 1'b1 || pending_mask !== 4'b0000) begin n_bad++;
      $display("FAIL mid_async wr=%b pm=%b want 1/0000", rf_wr, pending_mask); end
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (mem[2] !== 16'h3333 || conflict_cnt !== 4'd0) begin n_bad++;
      $display("FAIL mid_keep mem2=%h cc=%0d want 3333/0", mem[2], conflict_cnt); end
  endtask

  task automatic test_saturate();
    req_valid = 3'b111;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      if (i == 13) begin
        n_cmp++; if (conflict_cnt !== 4'hE) begin n_bad++;
          $display("FAIL sat_14 got=%h want=E", conflict_cnt); end
      end
    end
    req_valid = 3'b000;
    n_cmp++; if (conflict_cnt !== 4'hF) begin n_bad++;
      $display("FAIL sat_21 got=%h want=F", conflict_cnt); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_hold();
    test_back_to_back();
    test_reset_midcycle();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
